// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs narrow beats into wide lane-masked words for the CDC FIFO write port
module fifo_wr_packer #(
    parameter int InW  = 8,
    parameter int OutW = 32,
    parameter int CntW = $clog2(OutW / InW + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [InW-1:0]        data_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [OutW-1:0]       data_o,
    output logic [OutW/InW-1:0]   mask_o,
    output logic                  idle_o
);
    localparam int Ratio = OutW / InW;

    generate
        if (OutW % InW != 0 || Ratio < 2) begin : g_bad_params
            $error("fifo_wr_packer: OutW must be a multiple of InW with OutW/InW >= 2");
        end
    endgenerate

    logic [OutW-1:0]  acc_q, acc_d, out_q, out_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Ratio-1:0] mask_q, mask_d;
    logic             flush_pend_q, flush_pend_d, vld_q, vld_d;
    logic             full, out_free, move, take;

    // Next-state: drain accumulator into the output register, then pack the incoming beat
    always_comb begin
        full     = cnt_q == CntW'(Ratio);
        out_free = !vld_q || ready_i;
        move     = (full || flush_pend_q) && out_free;
        ready_o  = rst_ni && ((!full && !flush_pend_q) || move);
        take     = valid_i && ready_o;
        acc_d    = move ? '0 : acc_q;
        cnt_d    = move ? '0 : cnt_q;
        for (int i = 0; i < Ratio; i++) begin
            if (take && cnt_d == CntW'(i)) acc_d[i*InW +: InW] = data_i;
            mask_d[i] = move ? (CntW'(i) < cnt_q) : mask_q[i];
        end
        cnt_d        = cnt_d + CntW'(take);
        flush_pend_d = (flush_pend_q && !move) || (flush_i && cnt_d != '0 && cnt_d != CntW'(Ratio));
        out_d        = move ? acc_q : out_q;
        vld_d        = move || (vld_q && !ready_i);
    end

    // State registers; reset discards any partial or held word
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            out_q        <= '0;
            mask_q       <= '0;
            vld_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            out_q        <= out_d;
            mask_q       <= mask_d;
            vld_q        <= vld_d;
        end
    end

    assign valid_o = vld_q;
    assign data_o  = out_q;
    assign mask_o  = mask_q;
    assign idle_o  = cnt_q == '0 && !flush_pend_q && !vld_q;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: directed checks of packing, streaming, backpressure, flush and reset
module tb_fifo_wr_packer;
    logic        clk_i = 1'b0;
    logic        rst_ni, valid_i, ready_o, flush_i, valid_o, ready_i, idle_o;
    logic [7:0]  data_i;
    logic [31:0] data_o;
    logic [3:0]  mask_o;
    int          passed = 0, total = 0, next, nacc;
    logic [31:0] words[$];

    fifo_wr_packer #(.InW(8), .OutW(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .mask_o(mask_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b1; data_i = 8'h55; flush_i = 1'b0; ready_i = 1'b1;
        step;
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        step; step;
        chk("rst_data", data_o, 32'd0);
        chk("rst_mask", 32'(mask_o), 32'd0);
        chk("rst_ready3", 32'(ready_o), 32'd0);
        rst_ni = 1'b1; valid_i = 1'b0;
        #1;
        chk("rel_ready", 32'(ready_o), 32'd1);
        chk("rel_idle", 32'(idle_o), 32'd1);

        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = 8'(8'h11 * (i + 1));
            step;
        end
        valid_i = 1'b0;
        chk("single_lat1", 32'(valid_o), 32'd0);
        step;
        chk("single_valid", 32'(valid_o), 32'd1);
        chk("single_data", data_o, 32'h44332211);
        chk("single_mask", 32'(mask_o), 32'hF);
        step;
        chk("single_drop", 32'(valid_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; data_i = 8'(i + 1);
            #1;
            chk("stream_ready", 32'(ready_o), 32'd1);
            step;
            if (i == 4) begin
                chk("stream_v1", 32'(valid_o), 32'd1);
                chk("stream_w1", data_o, 32'h04030201);
            end
        end
        valid_i = 1'b0;
        step;
        chk("stream_v2", 32'(valid_o), 32'd1);
        chk("stream_w2", data_o, 32'h08070605);
        step;
        chk("stream_idle", 32'(idle_o), 32'd1);

        ready_i = 1'b0; next = 1; nacc = 0;
        for (int i = 0; i < 12; i++) begin
            valid_i = 1'b1; data_i = 8'(next);
            #1;
            if (ready_o) begin nacc++; next++; end
            step;
            if (i >= 9) chk("bp_hold", data_o, 32'h04030201);
        end
        #1;
        chk("bp_accepted", 32'(nacc), 32'd8);
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        chk("bp_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_i = next <= 12; data_i = 8'(next);
            #1;
            if (valid_o && ready_i) words.push_back(data_o);
            if (valid_i && ready_o) next++;
            step;
        end
        valid_i = 1'b0;
        chk("bp_count", 32'(words.size()), 32'd3);
        if (words.size() == 3) begin
            chk("bp_w1", words[0], 32'h04030201);
            chk("bp_w2", words[1], 32'h08070605);
            chk("bp_w3", words[2], 32'h0C0B0A09);
        end
        chk("bp_idle", 32'(idle_o), 32'd1);

        valid_i = 1'b1; data_i = 8'hAA;
        step;
        data_i = 8'hBB; flush_i = 1'b1;
        step;
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_pre", 32'(valid_o), 32'd0);
        chk("flush_not_idle", 32'(idle_o), 32'd0);
        step;
        chk("flush_valid", 32'(valid_o), 32'd1);
        chk("flush_data", data_o, 32'h0000BBAA);
        chk("flush_mask", 32'(mask_o), 32'h3);
        step;
        chk("flush_done", 32'(idle_o), 32'd1);
        flush_i = 1'b1;
        step;
        flush_i = 1'b0;
        chk("idle_flush_idle", 32'(idle_o), 32'd1);
        step;
        chk("idle_flush_novalid", 32'(valid_o), 32'd0);

        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; data_i = 8'(8'hA1 + i);
            #1;
            chk("mid_ready", 32'(ready_o), 32'd1);
            step;
        end
        valid_i = 1'b0;
        chk("mid_stalled", data_o, 32'hA4A3A2A1);
        rst_ni = 1'b0;
        step;
        chk("mid_valid", 32'(valid_o), 32'd0);
        chk("mid_idle", 32'(idle_o), 32'd1);
        chk("mid_ready_low", 32'(ready_o), 32'd0);
        rst_ni = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("mid_no_out", {31'd0, valid_o}, 32'd0);
            chk("mid_no_data", data_o, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
